// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer
//   Walks every output element of a convolution layer and emits its write
//   address with a valid/ready handshake. Iteration order is filter innermost,
//   then output column, then output row. Addresses are produced by incremental
//   registers only (no multiplier on the output path) and wrap modulo 2^ADDR_W.
//
//   Parameters: IMG_HEIGHT, IMG_WIDTH, KERNEL, STRIDE, NUM_FILTERS,
//               LAYOUT (0 = filter-major, 1 = pixel-interleaved), ADDR_W.
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     clear          synchronous abort to IDLE (wins over start)
//     start          begin a sequence, sampled only in IDLE
//     base_addr      base address, captured on an accepted start
//     out_ready      consumer accepts the current element
//     out_valid      element valid (high exactly while running)
//     out_addr       registered write address
//     out_filter/out_row/out_col  indices of the current element
//     out_last       current element is the final one
//     busy           not idle
//     done           one-cycle completion pulse
//     stall_cnt      RUN cycles with out_ready low (saturating)
//   Optional feature macro: CONV_ADDR_STALL_CNT_EN enables stall_cnt;
//   without it stall_cnt is tied to zero.
module conv_addr_sequencer #(
  parameter int IMG_HEIGHT  = 28,
  parameter int IMG_WIDTH   = 28,
  parameter int KERNEL      = 3,
  parameter int STRIDE      = 1,
  parameter int NUM_FILTERS = 8,
  parameter int LAYOUT      = 0,
  parameter int ADDR_W      = 32,
  localparam int OUT_H = (IMG_HEIGHT - KERNEL) / STRIDE + 1,
  localparam int OUT_W = (IMG_WIDTH - KERNEL) / STRIDE + 1,
  localparam int FW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [FW-1:0]     out_filter,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  localparam int TOTAL = OUT_H * OUT_W * NUM_FILTERS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [FW-1:0]     F_MAX = FW'(NUM_FILTERS - 1);
  localparam logic [RW-1:0]     R_MAX = RW'(OUT_H - 1);
  localparam logic [CW-1:0]     C_MAX = CW'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] PLANE = ADDR_W'(OUT_H * OUT_W);

  logic [1:0]        state;
  logic [FW-1:0]     f_q, f_n;
  logic [RW-1:0]     r_q, r_n;
  logic [CW-1:0]     c_q, c_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] pix_q, pix_n;
  logic              last_q, last_n;
  logic              xfer;
  logic              f_wrap, c_wrap, r_wrap;

  assign xfer   = (state == RUN) && out_ready;
  assign f_wrap = (f_q == F_MAX);
  assign c_wrap = (c_q == C_MAX);
  assign r_wrap = (r_q == R_MAX);

  // Next element in iteration order. For filter-major layout, pix_q tracks
  // base + r*OUT_W + c (which steps by one whenever the filter index wraps)
  // and the address adds one plane per filter step; interleaved layout is
  // simply a running +1.
  always_comb begin
    f_n    = f_q;
    c_n    = c_q;
    r_n    = r_q;
    pix_n  = pix_q;
    addr_n = addr_q;
    if (f_wrap) begin
      f_n = '0;
      if (c_wrap) begin
        c_n = '0;
        r_n = r_wrap ? '0 : r_q + 1'b1;
      end else begin
        c_n = c_q + 1'b1;
      end
    end else begin
      f_n = f_q + 1'b1;
    end
    if (LAYOUT == 1) begin
      addr_n = addr_q + 1'b1;
    end else if (f_wrap) begin
      pix_n  = pix_q + 1'b1;
      addr_n = pix_q + 1'b1;
    end else begin
      addr_n = addr_q + PLANE;
    end
    last_n = (f_n == F_MAX) && (c_n == C_MAX) && (r_n == R_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      f_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
      pix_q  <= '0;
      last_q <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      f_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      addr_q <= '0;
      pix_q  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            f_q    <= '0;
            r_q    <= '0;
            c_q    <= '0;
            addr_q <= base_addr;
            pix_q  <= base_addr;
            last_q <= (TOTAL == 1);
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_q) begin
              state <= DONE;
            end else begin
              f_q    <= f_n;
              r_q    <= r_n;
              c_q    <= c_n;
              addr_q <= addr_n;
              pix_q  <= pix_n;
              last_q <= last_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid  = (state == RUN);
  assign out_addr   = addr_q;
  assign out_filter = f_q;
  assign out_row    = r_q;
  assign out_col    = c_q;
  assign out_last   = last_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

`ifdef CONV_ADDR_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (clear) begin
      stall_q <= '0;
    end else if ((state == IDLE) && start) begin
      stall_q <= '0;
    end else if ((state == RUN) && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Scoreboard bench for conv_addr_sequencer: stimulus pushes the expected
// element stream per instance, a negedge monitor compares every presented
// element (and the done pulse) against the queue front.
module tb_conv_addr_sequencer;

  typedef struct {
    logic [31:0] addr;
    int          f;
    int          r;
    int          c;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  start, clear, ready, valid, last, busy, done;
  logic [31:0] base [5];
  logic [31:0] st [5];

  logic [31:0] a0, a1, a2, a4;
  logic [7:0]  a3;
  logic [2:0]  f0, f1;
  logic [4:0]  r0, c0, r1, c1;
  logic [0:0]  f2, r2, c2, r3, c3, f4, r4, c4;
  logic [1:0]  f3;

  exp_t q [5][$];
  logic prev_lx [5];
  int   n = 0;
  int   err = 0;
  int   cyc;

  always #5 clk = ~clk;

  conv_addr_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .start(start[0]), .base_addr(base[0]),
    .out_ready(ready[0]), .out_valid(valid[0]), .out_addr(a0), .out_filter(f0),
    .out_row(r0), .out_col(c0), .out_last(last[0]), .busy(busy[0]), .done(done[0]),
    .stall_cnt(st[0]));

  conv_addr_sequencer #(.LAYOUT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .start(start[1]), .base_addr(base[1]),
    .out_ready(ready[1]), .out_valid(valid[1]), .out_addr(a1), .out_filter(f1),
    .out_row(r1), .out_col(c1), .out_last(last[1]), .busy(busy[1]), .done(done[1]),
    .stall_cnt(st[1]));

  conv_addr_sequencer #(.IMG_HEIGHT(6), .IMG_WIDTH(6), .KERNEL(3), .STRIDE(2),
                        .NUM_FILTERS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]), .start(start[2]), .base_addr(base[2]),
    .out_ready(ready[2]), .out_valid(valid[2]), .out_addr(a2), .out_filter(f2),
    .out_row(r2), .out_col(c2), .out_last(last[2]), .busy(busy[2]), .done(done[2]),
    .stall_cnt(st[2]));

  conv_addr_sequencer #(.IMG_HEIGHT(4), .IMG_WIDTH(4), .KERNEL(3), .NUM_FILTERS(4),
                        .LAYOUT(1), .ADDR_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear[3]), .start(start[3]), .base_addr(base[3][7:0]),
    .out_ready(ready[3]), .out_valid(valid[3]), .out_addr(a3), .out_filter(f3),
    .out_row(r3), .out_col(c3), .out_last(last[3]), .busy(busy[3]), .done(done[3]),
    .stall_cnt(st[3]));

  conv_addr_sequencer #(.IMG_HEIGHT(3), .IMG_WIDTH(3), .KERNEL(3),
                        .NUM_FILTERS(1)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear[4]), .start(start[4]), .base_addr(base[4]),
    .out_ready(ready[4]), .out_valid(valid[4]), .out_addr(a4), .out_filter(f4),
    .out_row(r4), .out_col(c4), .out_last(last[4]), .busy(busy[4]), .done(done[4]),
    .stall_cnt(st[4]));

  task automatic cmp(input string nm, input longint act, input longint exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected stream from the address formulas (row outer, filter inner).
  task automatic push_seq(input int i, input int oh, input int ow, input int nf,
                          input int layout, input longint b, input int aw);
    exp_t   e;
    longint a;
    longint m;
    m = (longint'(1) << aw) - 1;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++)
        for (int f = 0; f < nf; f++) begin
          if (layout == 0) a = b + f * oh * ow + r * ow + c;
          else             a = b + (r * ow + c) * nf + f;
          e.addr = 32'(a & m);
          e.f = f;
          e.r = r;
          e.c = c;
          e.last = (r == oh - 1) && (c == ow - 1) && (f == nf - 1);
          q[i].push_back(e);
        end
  endtask

  task automatic mon(input int i, input logic [31:0] a, input int f, input int r,
                     input int c, input logic l);
    exp_t e;
    logic exp_d;
    if (rst_n !== 1'b1) begin
      prev_lx[i] = 1'b0;
      return;
    end
    exp_d = prev_lx[i];
    if (exp_d || done[i]) cmp($sformatf("u%0d done", i), longint'(done[i]), longint'(exp_d));
    prev_lx[i] = 1'b0;
    if (valid[i]) begin
      if (q[i].size() == 0) begin
        n++;
        err++;
        $display("FAIL u%0d unexpected element: addr %0d f%0d r%0d c%0d, none expected",
                 i, a, f, r, c);
      end else begin
        e = q[i][0];
        n++;
        if (a !== e.addr || f != e.f || r != e.r || c != e.c || l !== e.last) begin
          err++;
          $display("FAIL u%0d element: got addr %0d f%0d r%0d c%0d last %0b, expected addr %0d f%0d r%0d c%0d last %0b",
                   i, a, f, r, c, l, e.addr, e.f, e.r, e.c, e.last);
        end
        if (ready[i]) begin
          void'(q[i].pop_front());
          prev_lx[i] = l && !clear[i];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a0, int'(f0), int'(r0), int'(c0), last[0]);
    mon(1, a1, int'(f1), int'(r1), int'(c1), last[1]);
    mon(2, a2, int'(f2), int'(r2), int'(c2), last[2]);
    mon(3, {24'd0, a3}, int'(f3), int'(r3), int'(c3), last[3]);
    mon(4, a4, int'(f4), int'(r4), int'(c4), last[4]);
  end

  task automatic do_start(input int i, input logic [31:0] b);
    start[i] = 1'b1;
    base[i]  = b;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  // Counts cycles until done; leaves the caller one cycle later, back in IDLE.
  task automatic wait_done(input int i, input int budget, output int cycles);
    cycles = 0;
    while (!done[i] && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!done[i]) begin
      n++;
      err++;
      $display("FAIL u%0d done timeout: no done after %0d cycles", i, cycles);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = '0;
    clear = '0;
    ready = '1;
    for (int i = 0; i < 5; i++) begin
      base[i] = '0;
      prev_lx[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-run: async clear of everything, no done afterwards.
    push_seq(0, 26, 26, 8, 0, 0, 32);
    do_start(0, 32'd0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst valid", longint'(valid[0]), 0);
    cmp("rst last", longint'(last[0]), 0);
    cmp("rst busy", longint'(busy[0]), 0);
    cmp("rst done", longint'(done[0]), 0);
    cmp("rst addr", longint'(a0), 0);
    cmp("rst idx", longint'({f0, r0, c0}), 0);
    cmp("rst stall", longint'(st[0]), 0);
    q[0].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Full filter-major run; a start mid-run must be ignored.
    push_seq(0, 26, 26, 8, 0, 0, 32);
    do_start(0, 32'd0);
    repeat (20) @(posedge clk);
    #1 start[0] = 1'b1;
    base[0] = 32'd77;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 6000, cyc);
    cmp("u0 run drained", q[0].size(), 0);

    // Five backpressure cycles mid-run.
    push_seq(0, 26, 26, 8, 0, 1000, 32);
    do_start(0, 32'd1000);
    repeat (50) @(posedge clk);
    #1 ready[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 ready[0] = 1'b1;
    wait_done(0, 6000, cyc);
    cmp("u0 stall drained", q[0].size(), 0);
`ifdef CONV_ADDR_STALL_CNT_EN
    cmp("u0 stall_cnt", longint'(st[0]), 5);
`else
    cmp("u0 stall_cnt", longint'(st[0]), 0);
`endif

    // Clear on the 100th transfer.
    push_seq(0, 26, 26, 8, 0, 0, 32);
    do_start(0, 32'd0);
    repeat (99) @(posedge clk);
    #1 clear[0] = 1'b1;
    @(posedge clk);
    #1 clear[0] = 1'b0;
    cmp("u0 popped before clear", q[0].size(), 5408 - 100);
    q[0].delete();
    cmp("clr valid", longint'(valid[0]), 0);
    cmp("clr busy", longint'(busy[0]), 0);
    cmp("clr done", longint'(done[0]), 0);
    cmp("clr idx", longint'({f0, r0, c0}), 0);
    cmp("clr stall", longint'(st[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    // start together with clear: clear wins.
    start[0] = 1'b1;
    clear[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    clear[0] = 1'b0;
    cmp("start+clear busy", longint'(busy[0]), 0);
    push_seq(0, 26, 26, 8, 0, 500, 32);
    do_start(0, 32'd500);
    wait_done(0, 6000, cyc);
    cmp("u0 restart cycles", cyc, 5409);
    cmp("u0 restart drained", q[0].size(), 0);

    // Pixel-interleaved run: one element per cycle, no bubbles.
    push_seq(1, 26, 26, 8, 1, 0, 32);
    do_start(1, 32'd0);
    wait_done(1, 6000, cyc);
    cmp("u1 cycles", cyc, 5409);
    cmp("u1 drained", q[1].size(), 0);

    // 6x6, kernel 3, stride 2, one filter.
    push_seq(2, 2, 2, 1, 0, 0, 32);
    do_start(2, 32'd0);
    wait_done(2, 100, cyc);
    cmp("u2 cycles", cyc, 5);
    cmp("u2 drained", q[2].size(), 0);

    // 8-bit addresses wrapping from 255 to 0.
    push_seq(3, 2, 2, 4, 1, 250, 8);
    do_start(3, 32'd250);
    wait_done(3, 100, cyc);
    cmp("u3 cycles", cyc, 17);
    cmp("u3 drained", q[3].size(), 0);

    // Single-element sequence.
    push_seq(4, 1, 1, 1, 0, 32'h1234, 32);
    do_start(4, 32'h1234);
    wait_done(4, 100, cyc);
    cmp("u4 cycles", cyc, 2);
    cmp("u4 drained", q[4].size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end

endmodule

// File: doc/conv_addr_sequencer.md
CONV_ADDR_SEQUENCER -- requirements
Module: conv_addr_sequencer

Interface
REQ-001 Parameter IMG_HEIGHT, default 28, input feature-map rows.
REQ-002 Parameter IMG_WIDTH, default 28, input feature-map columns.
REQ-003 Parameter KERNEL, default 3, square kernel size.
REQ-004 Parameter STRIDE, default 1, window step in both dimensions.
REQ-005 Parameter NUM_FILTERS, default 8, output channels.
REQ-006 Parameter LAYOUT, default 0: 0 = filter-major, 1 = pixel-interleaved.
REQ-007 Parameter ADDR_W, default 32, address width.
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 clear  input  1  synchronous abort to IDLE.
REQ-011 start  input  1  begin sequence; sampled only in IDLE.
REQ-012 base_addr  input  ADDR_W  base address, captured on accepted start.
REQ-013 out_ready  input  1  consumer accepts current address.
REQ-014 out_valid  output  1  out_addr and indices valid.
REQ-015 out_addr  output  ADDR_W  write address, registered.
REQ-016 out_filter / out_row / out_col  output  max(1,clog2(N))  current filter, output row, output column.
REQ-017 out_last  output  1  current element is final of sequence.
REQ-018 busy  output  1  state is not IDLE.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 stall_cnt  output  32  backpressure cycle count (see Configuration).

Function
REQ-021 OUT_H = (IMG_HEIGHT-KERNEL)/STRIDE+1, OUT_W = (IMG_WIDTH-KERNEL)/STRIDE+1, TOTAL = OUT_H*OUT_W*NUM_FILTERS; integer division.
REQ-022 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on transfer with out_last; DONE->IDLE unconditionally after one cycle.
REQ-023 Transfer = out_valid && out_ready in the same cycle.
REQ-024 Iteration order: filter innermost, then column, then row.
REQ-025 out_valid is 1 exactly in RUN; first element (f0,r0,c0) is presented the cycle after start.
REQ-026 Without a transfer, out_addr, out_filter, out_row, out_col, out_last hold.
REQ-027 After a transfer the next element is presented the next cycle; no bubble.
REQ-028 LAYOUT 0: out_addr = base + f*OUT_H*OUT_W + r*OUT_W + c.
REQ-029 LAYOUT 1: out_addr = base + (r*OUT_W + c)*NUM_FILTERS + f.
REQ-030 Address arithmetic is modulo 2^ADDR_W; no overflow flag.
REQ-031 out_addr is computed by incremental counters/registers, no combinational multiply on the output path.
REQ-032 out_last = 1 only for (NUM_FILTERS-1, OUT_H-1, OUT_W-1).
REQ-033 done = 1 only in DONE.
REQ-034 start outside IDLE is ignored; start and clear together: clear wins.
REQ-035 clear in any state: next cycle IDLE, indices 0, out_valid 0, no done pulse.
REQ-036 NUM_FILTERS = 1 and OUT_H = OUT_W = 1 are legal; single-element sequence sets out_last on first element.

Reset
REQ-037 rst_n low asynchronously forces IDLE; out_valid, out_last, busy, done = 0; out_addr, indices, stall_cnt = 0.
REQ-038 Reset mid-RUN abandons the sequence; no done pulse is produced.

Configuration
REQ-039 Macro CONV_ADDR_STALL_CNT_EN defined: stall_cnt increments each RUN cycle with out_ready low, saturates at 2^32-1, clears on accepted start, clear and reset.
REQ-040 Macro undefined: stall_cnt is tied to 0 and no counter logic exists; all other behaviour identical.

Verification
REQ-041 Defaults, base 0, out_ready held 1: 5408 transfers; first three addrs 0, 676, 1352; 9th addr 1; last addr 5407 with out_last; done one cycle later.
REQ-042 LAYOUT 1, defaults: addrs 0..5407 strictly sequential, one per cycle.
REQ-043 IMG 6x6, KERNEL 3, STRIDE 2, NUM_FILTERS 1: OUT 2x2; addrs 0,1,2,3; rows/cols (0,0),(0,1),(1,0),(1,1).
REQ-044 out_ready low 5 cycles mid-run: outputs hold; stall_cnt = 5 with macro, 0 without.
REQ-045 clear on transfer 100: next cycle IDLE, out_valid 0, no done; new start restarts at base.
REQ-046 ADDR_W 8, LAYOUT 1, base 250: addrs 250..255 then 0, 1, ...
